addsub_mw_seq: RTL and testbench
================================

// Module: addsub_mw_seq
// PURPOSE
//  Multi-word sequencer for the shared 32-bit carry-lookahead add/sub unit.
//  Takes a command (add/sub, length in 32-bit words), streams operand words LSW-first
//  through the unit one per cycle, and chains carry between words through an internal
//  register. Emits a result stream with a final carry and signed-overflow flag.
//  Sits between the operand/result buffers and a single external add/sub instance.
// PARAMETERS
//  MAX_WORDS  4  maximum operand length in 32-bit words (>=1)
//  LEN_W      3  width of cmd_len; must hold MAX_WORDS
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst        in   1     synchronous reset, active-high
//  cmd_valid  in   1     command offered
//  cmd_ready  out  1     command accepted when cmd_valid&cmd_ready
//  cmd_sub    in   1     0 = add, 1 = subtract (A - B)
//  cmd_len    in   LEN_W number of words, legal 1..MAX_WORDS
//  in_valid   in   1     operand word pair offered
//  in_ready   out  1     operand word accepted when in_valid&in_ready
//  in_a       in   32    A word, LSW first
//  in_b       in   32    B word, LSW first
//  au_a       out  32    to add/sub unit operand a
//  au_b       out  32    to add/sub unit operand b
//  au_ctrl    out  1     to unit: 1 = invert b (subtract)
//  au_cin     out  1     to unit carry-in
//  au_s       in   32    from unit: au_a + (au_ctrl ? ~au_b : au_b) + au_cin (comb.)
//  au_cout    in   1     from unit carry-out (comb.)
//  out_valid  out  1     result word valid
//  out_ready  in   1     consumer accepts result word
//  out_s      out  32    result word
//  out_last   out  1     marks final word of command
//  out_carry  out  1     final carry-out (sub: 1 = no borrow); meaningful with out_last
//  out_ovf    out  1     signed overflow of full-width op; meaningful with out_last
//  busy       out  1     state != IDLE
//  err        out  1     one-cycle pulse: illegal cmd_len dropped
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1; in_ready=0; out_valid=0; out_s=0; out_last=0;
//   out_carry=0; out_ovf=0; busy=0; err=0; word counter, carry_q, sub_q cleared.
//  FSM IDLE -> RUN -> DRAIN -> IDLE.
//  IDLE: cmd_ready=1. On cmd handshake with 1<=cmd_len<=MAX_WORDS: latch sub_q, len_q,
//   cnt=0 -> RUN. cmd_len==0 or >MAX_WORDS: command consumed, err=1 next cycle, stay IDLE.
//  RUN: in_ready = !out_valid | out_ready (single output register, full throughput).
//   au_a=in_a, au_b=in_b, au_ctrl=sub_q, au_cin = (cnt==0) ? sub_q : carry_q (comb.).
//   On in handshake: out_s<=au_s, out_valid<=1, carry_q<=au_cout, cnt<=cnt+1;
//   if cnt==len_q-1: out_last<=1, out_carry<=au_cout,
//   out_ovf<=(a31==beff31)&(s31!=a31), beff=sub_q?~in_b:in_b -> DRAIN.
//  Output: result word appears the cycle after its input handshake (latency 1);
//   out_* held stable while out_valid&!out_ready; cleared out_valid on handshake unless
//   a new word loads the same cycle.
//  DRAIN: in_ready=0; on out handshake of last word -> IDLE (cmd_ready high next cycle).
//  No in-handshake outside RUN; in_valid in IDLE/DRAIN is ignored, not consumed.
//  carry_q updates only on in handshake; stalls never alter the carry chain.
//  Reset mid-op: partial result discarded, outputs to reset values next cycle.
// TESTING
//  add len1 A=FFFFFFFF B=00000001 -> out_s=00000000 last=1 carry=1 ovf=0
//  add len2 A={0,FFFFFFFF} B={0,1} -> words 00000000,00000001; carry=0 ovf=0
//  sub len2 A={1,0} B={0,1} -> words FFFFFFFF,00000000; carry=1 (no borrow)
//  sub len1 A=80000000 B=00000001 -> out_s=7FFFFFFF ovf=1; add 7FFFFFFF+1 -> ovf=1
//  len4 add, out_ready low 3 cycles mid-stream -> in_ready low, no lost/dup words, sum exact
//  cmd_len=0 and =5 -> err pulse, busy=0; rst during RUN -> out_valid=0, cmd_ready=1 next cycle

Source files
------------

// File: rtl/addsub_mw_seq.sv
// addsub_mw_seq: multi-word sequencer for an external 32-bit add/sub unit.
// A command is accepted, operand word pairs stream through the unit LSW first,
// and the carry is chained between words. The result stream carries a final
// carry and a signed-overflow flag on its last word.
//
// Handshake rule on every interface (cmd, in, out): a transfer happens on a
// rising clk edge where valid and ready are both high. A producer holds its
// payload stable while valid is high and ready is low. Ready may depend
// combinationally on the consumer side (in_ready follows out_ready), but
// valid never depends on ready.
module addsub_mw_seq #(
  parameter int MAX_WORDS = 4,
  parameter int LEN_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_sub,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      au_a,
  output logic [31:0]      au_b,
  output logic             au_ctrl,
  output logic             au_cin,
  input  logic [31:0]      au_s,
  input  logic             au_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_s,
  output logic             out_last,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] ZERO    = '0;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_s_q, out_s_d;
  logic             out_last_q, out_last_d;
  logic             out_carry_q, out_carry_d;
  logic             out_ovf_q, out_ovf_d;
  logic             err_q, err_d;

  logic cmd_hs;
  logic in_hs;
  logic out_hs;
  logic len_legal;
  logic last_word;
  logic beff_msb;

  // Handshake qualifiers and unit drive; the unit is purely combinational.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    cmd_hs    = cmd_valid && cmd_ready;
    in_hs     = in_valid && in_ready;
    out_hs    = out_valid_q && out_ready;
    len_legal = (cmd_len != ZERO) && (cmd_len <= MAX_LEN);
    last_word = (cnt_q == (len_q - ONE));
    beff_msb  = sub_q ? ~in_b[31] : in_b[31];
    au_a      = in_a;
    au_b      = in_b;
    au_ctrl   = sub_q;
    // First word takes the subtract "+1"; later words take the chained carry.
    au_cin    = (cnt_q == ZERO) ? sub_q : carry_q;
  end

  // Next-state: command capture, carry chain, single output register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_last_d  = out_last_q;
    out_carry_d = out_carry_q;
    out_ovf_d   = out_ovf_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          if (len_legal) begin
            sub_d   = cmd_sub;
            len_d   = cmd_len;
            cnt_d   = ZERO;
            carry_d = 1'b0;
            state_d = RUN;
          end else begin
            // Illegal length: the command is consumed and flagged, no work done.
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (in_hs) begin
          carry_d = au_cout;
          cnt_d   = cnt_q + ONE;
          if (last_word) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_hs && out_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new word may load in the same cycle the previous one is taken.
    if (in_hs) begin
      out_valid_d = 1'b1;
      out_s_d     = au_s;
      out_last_d  = last_word;
      if (last_word) begin
        out_carry_d = au_cout;
        out_ovf_d   = (in_a[31] == beff_msb) && (au_s[31] != in_a[31]);
      end
    end else if (out_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // State register with synchronous reset; reset drops any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_last_q  <= out_last_d;
      out_carry_q <= out_carry_d;
      out_ovf_q   <= out_ovf_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_last  = out_last_q;
  assign out_carry = out_carry_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_addsub_mw_seq.sv
// tb_addsub_mw_seq: directed bench for addsub_mw_seq with a behavioural
// add/sub unit, hand-computed result words and flags.
module tb_addsub_mw_seq;

  localparam int LEN_W = 3;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_sub;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      au_a;
  logic [31:0]      au_b;
  logic             au_ctrl;
  logic             au_cin;
  logic [31:0]      au_s;
  logic             au_cout;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_s;
  logic             out_last;
  logic             out_carry;
  logic             out_ovf;
  logic             busy;
  logic             err;

  int n_checks;
  int n_fail;
  int stall_left;
  logic [31:0] exp_q[$];

  addsub_mw_seq #(.MAX_WORDS(4), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sub(cmd_sub), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .au_a(au_a), .au_b(au_b), .au_ctrl(au_ctrl), .au_cin(au_cin),
    .au_s(au_s), .au_cout(au_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_last(out_last), .out_carry(out_carry), .out_ovf(out_ovf),
    .busy(busy), .err(err)
  );

  // External add/sub unit model.
  logic [32:0] au_sum;
  assign au_sum  = {1'b0, au_a} + {1'b0, (au_ctrl ? ~au_b : au_b)} + {32'b0, au_cin};
  assign au_s    = au_sum[31:0];
  assign au_cout = au_sum[32];

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic sub, input logic [LEN_W-1:0] len);
    int t;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_sub   = sub;
    cmd_len   = len;
    t = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        break;
      end
      t++;
      if (t > 50) begin
        check("cmd_timeout", 32'd1, 32'd0);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drive_words(input int len, input logic [127:0] a, input logic [127:0] b);
    int t;
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_a = a[32*i +: 32];
      in_b = b[32*i +: 32];
      t = 0;
      forever begin
        @(negedge clk); #1;
        if (in_ready) begin
          @(posedge clk); #1;
          break;
        end
        t++;
        if (t > 100) begin
          check("in_timeout", 32'd1, 32'd0);
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic recv_words(input int len, input logic c, input logic o, input int stall_at);
    int t;
    logic [31:0] exp_w;
    for (int i = 0; i < len; i++) begin
      if (i == stall_at) stall_left = 3;
      t = 0;
      forever begin
        @(negedge clk);
        if (stall_left > 0 && out_valid) begin
          out_ready = 1'b0;
          stall_left--;
          #1;
          check("in_ready_stall", {31'b0, in_ready}, 32'd0);
        end else begin
          out_ready = 1'b1;
          if (out_valid) begin
            exp_w = exp_q.pop_front();
            check("out_s", out_s, exp_w);
            check("out_last", {31'b0, out_last}, {31'b0, (i == len - 1)});
            if (i == len - 1) begin
              check("out_carry", {31'b0, out_carry}, {31'b0, c});
              check("out_ovf", {31'b0, out_ovf}, {31'b0, o});
            end
            break;
          end
        end
        t++;
        if (t > 100) begin
          check("out_timeout", 32'd1, 32'd0);
          break;
        end
      end
    end
    out_ready = 1'b1;
  endtask

  // One command end to end: a, b, e hold words LSW at [31:0].
  task automatic run_op(input logic sub, input int len, input logic [127:0] a,
                        input logic [127:0] b, input logic [127:0] e,
                        input logic c, input logic o, input int stall_at);
    for (int i = 0; i < len; i++) exp_q.push_back(e[32*i +: 32]);
    send_cmd(sub, LEN_W'(len));
    fork
      drive_words(len, a, b);
      recv_words(len, c, o, stall_at);
    join
    @(posedge clk);
    @(negedge clk);
    check("cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
    check("busy_after", {31'b0, busy}, 32'd0);
    check("exp_q_empty", exp_q.size(), 32'd0);
  endtask

  task automatic bad_len(input logic [LEN_W-1:0] len);
    send_cmd(1'b0, len);
    @(negedge clk);
    check("err_pulse", {31'b0, err}, 32'd1);
    check("err_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("err_clear", {31'b0, err}, 32'd0);
    check("err_cmd_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    stall_left = 0;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_sub    = 1'b0;
    cmd_len    = '0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_s", out_s, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_out_carry", {31'b0, out_carry}, 32'd0);
    check("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);

    // Operand offered in IDLE is not taken.
    in_valid = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 32'd0);
    in_valid = 1'b0;

    // add len1: FFFFFFFF + 1.
    run_op(1'b0, 1, 128'hFFFFFFFF, 128'h1, 128'h0, 1'b1, 1'b0, -1);
    // add len2: {0,FFFFFFFF} + {0,1}.
    run_op(1'b0, 2, 128'h0_FFFFFFFF, 128'h0_00000001, 128'h00000001_00000000, 1'b0, 1'b0, -1);
    // sub len2: {1,0} - {0,1}.
    run_op(1'b1, 2, 128'h00000001_00000000, 128'h00000000_00000001,
           128'h00000000_FFFFFFFF, 1'b1, 1'b0, -1);
    // sub len1: 80000000 - 1 overflows.
    run_op(1'b1, 1, 128'h80000000, 128'h1, 128'h7FFFFFFF, 1'b1, 1'b1, -1);
    // add len1: 7FFFFFFF + 1 overflows.
    run_op(1'b0, 1, 128'h7FFFFFFF, 128'h1, 128'h80000000, 1'b0, 1'b1, -1);
    // sub len3: 5 - 6 borrows through all words.
    run_op(1'b1, 3, 128'h0_00000000_00000000_00000005, 128'h0_00000000_00000000_00000006,
           128'h0_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0, 1'b0, -1);
    // add len4 with a three-cycle output stall mid-stream.
    run_op(1'b0, 4, 128'h00000000_12345678_FFFFFFFF_FFFFFFFF,
           128'h00000000_EDCBA988_00000000_00000001,
           128'h00000001_00000001_00000000_00000000, 1'b0, 1'b0, 2);

    // Illegal lengths.
    bad_len(3'd0);
    bad_len(3'd5);
    bad_len(3'd7);

    // Reset in the middle of a run.
    send_cmd(1'b0, 3'd4);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'h1;
    in_b      = 32'h2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_out_s", out_s, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);

    // Fresh command after the reset starts a clean carry chain.
    run_op(1'b0, 2, 128'h0_FFFFFFFF, 128'h0_00000001, 128'h00000001_00000000, 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
